// File: rtl/deser_pkg.sv
// -----------------------------------------------------------------------------
// deser_pkg
//   Shared definitions for the deser_demux8 serial-to-parallel receiver:
//   FSM state encoding, word/slot widths and the start/last slot values for
//   each bit-order setting.
//   Optional feature macro used by the users of this package:
//   DESER_DEMUX8_PARITY_EN (enables the PAR state).
// -----------------------------------------------------------------------------
package deser_pkg;

    typedef enum logic {
        FILL = 1'b0,   // collecting data bits
        PAR  = 1'b1    // waiting for the trailing parity bit
    } state_t;

    localparam int WORD_W = 8;
    localparam int SLOT_W = 3;

    localparam logic [SLOT_W-1:0] SLOT_START_LSB = 3'd0;
    localparam logic [SLOT_W-1:0] SLOT_LAST_LSB  = 3'd7;
    localparam logic [SLOT_W-1:0] SLOT_START_MSB = 3'd7;
    localparam logic [SLOT_W-1:0] SLOT_LAST_MSB  = 3'd0;

    function automatic logic [SLOT_W-1:0] start_slot(input logic lsb_first);
        return lsb_first ? SLOT_START_LSB : SLOT_START_MSB;
    endfunction

    function automatic logic [SLOT_W-1:0] last_slot(input logic lsb_first);
        return lsb_first ? SLOT_LAST_LSB : SLOT_LAST_MSB;
    endfunction

endpackage

// File: rtl/deser_demux8_slot_ctr3.sv
// -----------------------------------------------------------------------------
// slot_ctr3
//   3-bit up/down counter with synchronous load and enable; o_tc flags that
//   the count equals TC_VAL (the last slot of a word).
//   Ports:
//     clk, rst_n   clock, asynchronous active-low reset (count -> RST_VAL)
//     i_load       load i_load_val (wins over i_en)
//     i_load_val   value to load
//     i_en         step the count by one
//     i_up         1: count up, 0: count down
//     o_cnt        current count
//     o_tc         count == TC_VAL
// -----------------------------------------------------------------------------
module slot_ctr3
    import deser_pkg::*;
#(
    parameter logic [SLOT_W-1:0] RST_VAL = 3'd0,
    parameter logic [SLOT_W-1:0] TC_VAL  = 3'd7
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              i_load,
    input  logic [SLOT_W-1:0] i_load_val,
    input  logic              i_en,
    input  logic              i_up,
    output logic [SLOT_W-1:0] o_cnt,
    output logic              o_tc
);

    logic [SLOT_W-1:0] r_cnt;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_cnt <= RST_VAL;
        end else if (i_load) begin
            r_cnt <= i_load_val;
        end else if (i_en) begin
            r_cnt <= i_up ? (r_cnt + 3'd1) : (r_cnt - 3'd1);
        end
    end

    assign o_cnt = r_cnt;
    assign o_tc  = (r_cnt == TC_VAL);

endmodule

// File: rtl/deser_demux8.sv
// -----------------------------------------------------------------------------
// deser_demux8
//   Serial-to-parallel receiver. Each accepted serial bit is steered by the
//   slot counter into one bit of an assembly register; a complete word moves
//   into a single output holding register with a valid/ready handshake.
//   Optional feature macro: DESER_DEMUX8_PARITY_EN -- a 9th serial bit carries
//   even parity and sets dout_err for the word.
//   Ports:
//     clk, rst_n        clock, asynchronous active-low reset
//     din, din_valid    serial bit and its valid
//     din_ready         block accepts din this cycle
//     clr               synchronous discard of the partial word
//     s                 current demux slot (position for the next data bit)
//     dout, dout_valid  assembled word and its valid
//     dout_ready        consumer takes dout
//     dout_err          parity error for dout (0 without the feature)
//
//   Handshake: a beat moves when valid && ready in the same cycle; a producer
//   holding valid keeps its payload stable until ready is seen. Only the step
//   that completes a word can be stalled, and only when dout is still full and
//   the consumer is not draining it this cycle.
// -----------------------------------------------------------------------------
module deser_demux8
    import deser_pkg::*;
#(
    parameter int WIDTH     = 8,
    parameter int SW        = 3,
    parameter int LSB_FIRST = 1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             din,
    input  logic             din_valid,
    output logic             din_ready,
    input  logic             clr,
    output logic [SW-1:0]    s,
    output logic [WIDTH-1:0] dout,
    output logic             dout_valid,
    input  logic             dout_ready,
    output logic             dout_err
);

    localparam logic          P_LSB   = (LSB_FIRST != 0);
    localparam logic [SW-1:0] P_START = start_slot(P_LSB);
    localparam logic [SW-1:0] P_LAST  = last_slot(P_LSB);

    state_t           r_state;
    state_t           w_state_nxt;
    logic [WIDTH-1:0] r_asm;
    logic [WIDTH-1:0] r_dout;
    logic             r_dout_valid;
    logic [SW-1:0]    w_slot;
    logic             w_tc;
    logic             w_accept;
    logic             w_final_step;
    logic             w_xfer;
    logic             w_ctr_load;
    logic             w_ctr_en;
    logic [WIDTH-1:0] w_word;

    slot_ctr3 #(
        .RST_VAL (P_START),
        .TC_VAL  (P_LAST)
    ) u_slot_ctr (
        .clk        (clk),
        .rst_n      (rst_n),
        .i_load     (w_ctr_load),
        .i_load_val (P_START),
        .i_en       (w_ctr_en),
        .i_up       (P_LSB),
        .o_cnt      (w_slot),
        .o_tc       (w_tc)
    );

    // The step that completes a word: the last data bit, or with parity
    // enabled the parity bit taken in PAR.
`ifdef DESER_DEMUX8_PARITY_EN
    assign w_final_step = (r_state == PAR);
`else
    assign w_final_step = (r_state == FILL) && w_tc;
`endif

    assign din_ready  = !(w_final_step && r_dout_valid && !dout_ready);
    assign w_accept   = din_valid && din_ready;
    assign w_xfer     = w_accept && w_final_step && !clr;
    assign w_ctr_load = clr || w_xfer;
    // In PAR the slot holds at its final data value; only data bits step it.
    assign w_ctr_en   = w_accept && !clr && (r_state == FILL) && !w_tc;

    // Word handed to dout: without parity the 8th bit is still in flight on
    // din, so it is merged here rather than waiting a cycle for r_asm.
    always_comb begin
        w_word = r_asm;
`ifndef DESER_DEMUX8_PARITY_EN
        w_word[w_slot] = din;
`endif
    end

    always_comb begin
        w_state_nxt = r_state;
        if (clr) begin
            w_state_nxt = FILL;
        end else if (w_accept) begin
`ifdef DESER_DEMUX8_PARITY_EN
            if (r_state == FILL && w_tc) begin
                w_state_nxt = PAR;
            end else if (r_state == PAR) begin
                w_state_nxt = FILL;
            end
`endif
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= FILL;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_asm <= '0;
        end else if (clr) begin
            r_asm <= '0;
        end else if (w_accept && r_state == FILL) begin
            r_asm[w_slot] <= din;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_dout       <= '0;
            r_dout_valid <= 1'b0;
        end else if (w_xfer) begin
            r_dout       <= w_word;
            r_dout_valid <= 1'b1;
        end else if (dout_ready) begin
            r_dout_valid <= 1'b0;
        end
    end

`ifdef DESER_DEMUX8_PARITY_EN
    logic r_dout_err;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_dout_err <= 1'b0;
        end else if (w_xfer) begin
            r_dout_err <= (^w_word) ^ din;
        end else if (dout_ready) begin
            r_dout_err <= 1'b0;
        end
    end

    assign dout_err = r_dout_err;
`else
    assign dout_err = 1'b0;
`endif

    assign s          = w_slot;
    assign dout       = r_dout;
    assign dout_valid = r_dout_valid;

endmodule
